// File: rtl/spi_slave_ctrl.sv
`timescale 1ns/1ps
// spi_slave_ctrl: SPI responder, all four CPOL/CPHA modes, MSB-first DW-bit words.
// SCLK, CS_N and MOSI are oversampled in the sys_clk domain. MISO is fed from a
// one-entry transmit buffer; each received word is presented with a 1-cycle pulse.
//
// Ports:
//   sys_clk, rst            system clock, synchronous active-high reset
//   spi_sclk/cs_n/mosi      asynchronous SPI pins from the master
//   spi_miso, spi_miso_oe   slave data out and pad output enable
//   cfg_cpol, cfg_cpha      mode select, captured while idle
//   tx_data/valid/ready     transmit buffer write handshake
//   rx_data, rx_valid       last received word and its update pulse
//   busy                    selected (synchronised CS low)
//
// Optional: define SPI_SLAVE_CTRL_STATUS_EN to add status_clr, tx_underrun and
// cs_abort (sticky flags; set has priority over clear).

module spi_slave_ctrl #(
    parameter int DW          = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic          sys_clk,
    input  logic          rst,
    input  logic          spi_sclk,
    input  logic          spi_cs_n,
    input  logic          spi_mosi,
    output logic          spi_miso,
    output logic          spi_miso_oe,
    input  logic          cfg_cpol,
    input  logic          cfg_cpha,
    input  logic [DW-1:0] tx_data,
    input  logic          tx_valid,
    output logic          tx_ready,
    output logic [DW-1:0] rx_data,
    output logic          rx_valid,
    output logic          busy
`ifdef SPI_SLAVE_CTRL_STATUS_EN
    ,
    input  logic          status_clr,
    output logic          tx_underrun,
    output logic          cs_abort
`endif
);

    // Synchroniser plus one extra stage whose output feeds edge detection.
    localparam int SN = SYNC_STAGES + 1;
    localparam int CW = $clog2(DW);

    typedef enum logic {
        IDLE,
        ACTIVE
    } state_e;

    state_e state_q, state_d;

    logic [SN-1:0] sclk_sync_q, cs_sync_q, mosi_sync_q;
    logic          sclk_prev_q, cs_prev_q;
    logic          cpol_q, cpha_q;

    logic [DW-1:0] tx_sr_q, tx_sr_d;
    logic [DW-1:0] rx_sr_q, rx_sr_d;
    logic [DW-1:0] rx_data_q, rx_data_d;
    logic [DW-1:0] buf_q, buf_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          buf_full_q, buf_full_d;
    logic          miso_q, miso_d;
    logic          skip_q, skip_d;
    logic          rx_valid_q, rx_valid_d;

    logic          sclk_s, cs_s, mosi_s;
    logic          cs_fall, cs_rise, sclk_chg, lead, trail;
    logic          start, stop, smp, shf, done, load, hs;
    logic [DW-1:0] load_word;

    // Input synchronisers and edge-detect history.
    always_ff @(posedge sys_clk) begin
        if (rst) begin
            sclk_sync_q <= '0;
            cs_sync_q   <= '1;
            mosi_sync_q <= '0;
            sclk_prev_q <= 1'b0;
            cs_prev_q   <= 1'b1;
        end else begin
            sclk_sync_q <= {sclk_sync_q[SN-2:0], spi_sclk};
            cs_sync_q   <= {cs_sync_q[SN-2:0], spi_cs_n};
            mosi_sync_q <= {mosi_sync_q[SN-2:0], spi_mosi};
            sclk_prev_q <= sclk_sync_q[SN-1];
            cs_prev_q   <= cs_sync_q[SN-1];
        end
    end

    assign sclk_s   = sclk_sync_q[SN-1];
    assign cs_s     = cs_sync_q[SN-1];
    assign mosi_s   = mosi_sync_q[SN-1];

    assign cs_fall  = cs_prev_q & ~cs_s;
    assign cs_rise  = ~cs_prev_q & cs_s;
    assign sclk_chg = sclk_s ^ sclk_prev_q;
    assign lead     = sclk_chg & (sclk_s != cpol_q);
    assign trail    = sclk_chg & (sclk_s == cpol_q);

    // A CS rise masks any SCLK edge seen in the same cycle.
    assign start    = (state_q == IDLE) & cs_fall;
    assign stop     = (state_q == ACTIVE) & cs_rise;
    assign smp      = (state_q == ACTIVE) & ~cs_rise & (cpha_q ? trail : lead);
    assign shf      = (state_q == ACTIVE) & ~cs_rise & (cpha_q ? lead : trail);
    assign done     = smp & (cnt_q == CW'(DW - 1));
    assign load     = start | done;
    assign load_word = buf_full_q ? buf_q : '0;
    assign hs       = tx_valid & ~buf_full_q;

    // State register.
    always_ff @(posedge sys_clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (cs_fall) state_d = ACTIVE;
            ACTIVE:  if (cs_rise) state_d = IDLE;
        endcase
    end

    // Outputs.
    always_comb begin
        busy        = (state_q == ACTIVE);
        spi_miso_oe = (state_q == ACTIVE);
        spi_miso    = miso_q;
        tx_ready    = ~buf_full_q;
        rx_data     = rx_data_q;
        rx_valid    = rx_valid_q;
    end

    // Shift datapath and transmit buffer.
    always_comb begin
        tx_sr_d    = tx_sr_q;
        rx_sr_d    = rx_sr_q;
        rx_data_d  = rx_data_q;
        rx_valid_d = 1'b0;
        cnt_d      = cnt_q;
        miso_d     = miso_q;
        skip_d     = skip_q;
        buf_d      = buf_q;
        buf_full_d = buf_full_q;

        if (stop) begin
            miso_d = 1'b0;
            cnt_d  = '0;
            skip_d = 1'b0;
        end else if (start) begin
            cnt_d  = '0;
            skip_d = 1'b0;
            if (cfg_cpha) begin
                tx_sr_d = load_word;
            end else begin
                miso_d  = load_word[DW-1];
                tx_sr_d = {load_word[DW-2:0], 1'b0};
            end
        end else begin
            if (smp) begin
                rx_sr_d = {rx_sr_q[DW-2:0], mosi_s};
                if (done) begin
                    cnt_d      = '0;
                    rx_data_d  = {rx_sr_q[DW-2:0], mosi_s};
                    rx_valid_d = 1'b1;
                    if (cpha_q) begin
                        tx_sr_d = load_word;
                    end else begin
                        // New MSB goes out now; the trailing edge that
                        // closes the old word must not shift it away.
                        miso_d  = load_word[DW-1];
                        tx_sr_d = {load_word[DW-2:0], 1'b0};
                        skip_d  = 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            if (shf) begin
                if (skip_q) begin
                    skip_d = 1'b0;
                end else begin
                    miso_d  = tx_sr_q[DW-1];
                    tx_sr_d = {tx_sr_q[DW-2:0], 1'b0};
                end
            end
        end

        // A handshake coinciding with a load refills the buffer for the next one.
        if (load) buf_full_d = 1'b0;
        if (hs) begin
            buf_full_d = 1'b1;
            buf_d      = tx_data;
        end
    end

    always_ff @(posedge sys_clk) begin
        if (rst) begin
            tx_sr_q    <= '0;
            rx_sr_q    <= '0;
            rx_data_q  <= '0;
            rx_valid_q <= 1'b0;
            cnt_q      <= '0;
            miso_q     <= 1'b0;
            skip_q     <= 1'b0;
            buf_q      <= '0;
            buf_full_q <= 1'b0;
            cpol_q     <= 1'b0;
            cpha_q     <= 1'b0;
        end else begin
            tx_sr_q    <= tx_sr_d;
            rx_sr_q    <= rx_sr_d;
            rx_data_q  <= rx_data_d;
            rx_valid_q <= rx_valid_d;
            cnt_q      <= cnt_d;
            miso_q     <= miso_d;
            skip_q     <= skip_d;
            buf_q      <= buf_d;
            buf_full_q <= buf_full_d;
            if (state_q == IDLE) begin
                cpol_q <= cfg_cpol;
                cpha_q <= cfg_cpha;
            end
        end
    end

`ifdef SPI_SLAVE_CTRL_STATUS_EN
    logic underrun_q, abort_q;

    always_ff @(posedge sys_clk) begin
        if (rst) begin
            underrun_q <= 1'b0;
            abort_q    <= 1'b0;
        end else begin
            if (load & ~buf_full_q) begin
                underrun_q <= 1'b1;
            end else if (status_clr) begin
                underrun_q <= 1'b0;
            end
            if (stop & (cnt_q != '0)) begin
                abort_q <= 1'b1;
            end else if (status_clr) begin
                abort_q <= 1'b0;
            end
        end
    end

    assign tx_underrun = underrun_q;
    assign cs_abort    = abort_q;
`endif

endmodule

// File: doc/spi_slave_ctrl.md
Name: spi_slave_ctrl

Overview:
- SPI responder: the far end of the link driven by the team's SPI master, whose clock generator produces SCLK from sys_clk.
- Oversamples SCLK, CS_N and MOSI in the sys_clk domain and shifts one DW-bit word per transfer, MSB first.
- Drives MISO from a one-entry transmit buffer; presents each received word to the SoC with a one-cycle valid pulse.
- Supports all four CPOL/CPHA modes.

Parameters:
- DW, 8, word width in bits; must be at least 2.
- SYNC_STAGES, 2, synchroniser flops on spi_sclk, spi_cs_n and spi_mosi; must be at least 2.

Ports:
- sys_clk  in  1  system clock; all logic runs on its rising edge.
- rst  in  1  synchronous, active-high reset.
- spi_sclk  in  1  serial clock from master; asynchronous to sys_clk.
- spi_cs_n  in  1  chip select, active low; asynchronous.
- spi_mosi  in  1  master-out data; asynchronous.
- spi_miso  out  1  slave-out data.
- spi_miso_oe  out  1  MISO output enable for the pad.
- cfg_cpol  in  1  SCLK idle level; sampled only while in IDLE.
- cfg_cpha  in  1  0 = sample on leading edge, 1 = sample on trailing edge; sampled only while in IDLE.
- tx_data  in  DW  next word to transmit.
- tx_valid  in  1  tx_data is valid.
- tx_ready  out  1  transmit buffer is empty.
- rx_data  out  DW  last complete received word; held until the next word completes.
- rx_valid  out  1  one-cycle pulse when rx_data updates.
- busy  out  1  selected (synchronised CS low).

Behaviour:
- Reset, synchronous on rst high, applied whatever state is current:
  - state = IDLE, bit counter = 0, tx buffer empty, shift registers = 0.
  - Synchroniser flops: spi_cs_n path to 1, spi_sclk path to 0, spi_mosi path to 0.
  - Outputs: spi_miso=0, spi_miso_oe=0, tx_ready=1, rx_data=0, rx_valid=0, busy=0.
- Inputs are synchronised through SYNC_STAGES flops; an extra flop stage provides edge detection.
- Edge definitions:
  - Leading edge: synchronised SCLK leaves the CPOL level.
  - Trailing edge: synchronised SCLK returns to the CPOL level.
  - Sample edge = leading when CPHA=0, trailing when CPHA=1; the other edge is the shift edge.
- SCLK high and low times must each be at least 2 sys_clk periods, i.e. master half-period delay of 1 or more.
- TX buffer:
  - Accepts when tx_valid && tx_ready; tx_ready then falls next cycle.
  - Buffer is consumed at each word load.
  - A load with an empty buffer transmits all zeros (underrun).
  - A tx handshake in the same cycle as a load does not feed that load; the word is held for the next load.
- State machine IDLE -> ACTIVE:
  - Transition on the synchronised CS falling edge.
  - Same cycle: load tx shift register, bit counter = 0, busy=1, spi_miso_oe=1.
  - CPHA=0: spi_miso = word bit DW-1 from the load cycle.
  - CPHA=1: spi_miso is updated on the first shift edge.
- ACTIVE, sample edge: shift synchronised MOSI into the rx shift register LSB; bit counter increments.
- ACTIVE, shift edge: advance spi_miso to the next bit.
  - CPHA=0: no shift on the trailing edge that ends a word.
- Word completion: the sample edge where bit counter reaches DW-1.
  - Next cycle: rx_data = assembled word, rx_valid=1 for exactly one cycle.
  - Counter wraps to 0; the tx shift register reloads from the buffer in that cycle for back-to-back words under one CS.
  - CPHA=0: MSB of the new word drives immediately.
- Latency: rx_valid rises SYNC_STAGES+2 sys_clk cycles after the final sample edge at the pin.
- ACTIVE -> IDLE on synchronised CS rising:
  - Partial word (counter != 0) is discarded; no rx_valid.
  - A loaded tx word is lost; the buffer is not restored.
  - spi_miso=0, spi_miso_oe=0, busy=0.
- CS rising in the same cycle as a sample edge: the CS rise wins and the edge is ignored.
- SCLK edges while in IDLE are ignored. CS glitches shorter than the synchroniser depth are not guaranteed to be seen.

Optional Feature:
- Macro: SPI_SLAVE_CTRL_STATUS_EN.
- When defined, adds:
  - input status_clr.
  - output tx_underrun: sticky; set when a load occurs with an empty tx buffer.
  - output cs_abort: sticky; set when CS rises with bit counter != 0.
- Flags reset to 0 on rst; status_clr clears them. Set wins over clear in the same cycle.
- When undefined, these ports and their logic are absent; all other behaviour is identical.

Test Plan:
- Mode 0, DW=8, tx_data=0xA5 written before CS, master sends 0x3C -> MISO bits 1,0,1,0,0,1,0,1; rx_data=0x3C; one rx_valid pulse; tx_ready returns to 1.
- Mode 3, two words under one CS, tx 0x81 then 0x7E (second written during word 1), master sends 0xF0 then 0x0F -> MISO 0x81 then 0x7E; rx_valid twice, with 0xF0 then 0x0F.
- Mode 1, no tx write -> MISO all zeros; received word correct; tx_underrun=1 if the macro is defined.
- CS rises after 5 bits in mode 2 -> no rx_valid; busy=0; spi_miso_oe=0; cs_abort=1 if the macro is defined; the next full transfer is received correctly.
- rst pulsed mid-word -> all outputs at reset values next cycle; the following transfer is clean.
- Master clock half-period of 2 sys_clk cycles in all four modes, random data over 100 words -> rx and MISO streams match the model bit-exactly.
